rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares a single 4:1 multiplexer between four requesters.
- Drives the mux select lines address1/address0 and a one-hot grant.
- Enforces a bounded hold time so that no requester can monopolise the shared path.
- Sits in front of the mux datapath. The selected input appears on out, qualified by valid.

Parameters:
- WIDTH, 1, data width of each input and of out.
- MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while other requests are pending. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- req  input  4  request per requester; bit i belongs to in{i}
- in0  input  WIDTH  data of requester 0
- in1  input  WIDTH  data of requester 1
- in2  input  WIDTH  data of requester 2
- in3  input  WIDTH  data of requester 3
- grant  output  4  registered one-hot grant; all-zero when idle
- address0  output  1  registered mux select LSB (owner index bit 0)
- address1  output  1  registered mux select MSB (owner index bit 1)
- out  output  WIDTH  selected input data; all-zero when valid=0
- valid  output  1  high when grant is non-zero

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values (take effect immediately on reset_n=0, independent of clk):
  - state=IDLE, grant=4'b0000, address1/address0=00, valid=0, out=0.
  - hold_cnt=0; last_owner=3, so requester 0 has top priority after reset.
- States: IDLE, OWN. State, grant, address, hold_cnt and last_owner are all registered.
- Round-robin pick: search order starts at last_owner+1 mod 4 and wraps, e.g. last_owner=2 gives order 3,0,1,2. The first requester with req set wins.
- IDLE:
  - If req!=0, pick a winner. Next edge: OWN, grant=onehot(winner), {address1,address0}=winner, hold_cnt=1, last_owner=winner.
  - Latency: 1 cycle from req assertion to grant.
- OWN (owner o):
  - Keep (req[o]=1 and (hold_cnt<MAX_HOLD or no other req)): grant unchanged. hold_cnt increments, saturating at MAX_HOLD.
  - Sole requester at MAX_HOLD: the owner is re-granted and hold_cnt stays at MAX_HOLD. There are no idle bubbles.
  - Release (req[o]=0, or hold_cnt==MAX_HOLD with another req pending):
    - If any req[j]=1 for j!=o, pick the winner from rotation after o, excluding o. Switch directly to it on the next edge with hold_cnt=1; no idle cycle between owners.
    - Otherwise go to IDLE with grant=0000. The address lines keep their last value.
- Dropped request: the owner dropping req loses the grant on the next edge. The grant is never revoked combinationally.
- Request raised in the same cycle as a release: included in that cycle's pick.
- out (combinational): out = in[{address1,address0}] when valid=1, else all-zero.
  - Unselected inputs, including X/Z values, must not affect out.
  - Zero-latency path from in{sel} to out.
- valid = |grant, combinational from the registered grant.
- Invariants:
  - grant is always zero or one-hot.
  - address always matches the index of the set grant bit.
- Reset mid-operation: all outputs clear asynchronously. After reset release, arbitration restarts with requester 0 first and hold_cnt=0.

Test Plan:
- Reset then single request: reset_n=0 for 2 cycles, release, req=0100 -> one edge later grant=0100, address1/address0=10, valid=1. out follows in2 (in2=1 gives out=1). in0/in1/in3=X gives no X on out.
- Simultaneous requests after reset: req=1111 held, MAX_HOLD=4 -> grant sequence 0001 x4 cycles, 0010 x4, 0100 x4, 1000 x4, then 0001 again. No zero-grant cycles between owners.
- Sole requester hold: req=0010 for 10 cycles -> grant=0010 for all cycles after the first edge. hold_cnt saturates at 4. No release.
- Early drop with handoff: owner 0 granted, req changes from 0011 to 0010 -> next edge grant=0010, address=01, hold_cnt=1. req=0000 after that -> grant=0000, valid=0, out=0, address stays 01.
- Rotation fairness: last_owner=2, req=0101 -> winner is 0 (order 3,0,1,2). Next release with req=0101 -> winner is 2.
- Async reset mid-grant: grant=1000 with reset_n pulsed low between clock edges -> grant=0000, valid=0, out=0 immediately. After release with req=1001 -> first grant is 0001.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// Request/data bundle between four requesters and the shared-mux arbiter.
// The requester side drives req and in0..in3. The arbiter drives grant, select, out and valid.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 1
);
  logic [3:0]       req;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [3:0]       grant;
  logic             address0;
  logic             address1;
  logic [WIDTH-1:0] out;
  logic             valid;

  modport master (
    output req, in0, in1, in2, in3,
    input  grant, address0, address1, out, valid
  );

  modport slave (
    input  req, in0, in1, in2, in3,
    output grant, address0, address1, out, valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with bounded hold time that steers one shared 4:1 mux.
// Grant and select are registered. The data path from the selected input to out is combinational.
module rr_mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input logic           clk,
  input logic           reset_n,
  rr_mux_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWN   = 1'b1;
  localparam logic [3:0] MAX_Q = 4'(MAX_HOLD);

  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       addr_q, addr_d;
  logic [3:0]       hold_q, hold_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       others;
  logic [2:0]       pick;
  logic             keep;
  logic [WIDTH-1:0] out_mux;

  // Returns {found, index}. The search starts at after+1 and wraps, so the first hit in rotation wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] after);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = after + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // In OWN, last_q equals the owner and grant_q masks it out. In IDLE, grant_q is zero.
  // One picker therefore serves both the fresh pick and the handoff.
  assign others = bus.req & ~grant_q;
  assign pick   = rr_pick(others, last_q);
  assign keep   = bus.req[addr_q] && ((hold_q < MAX_Q) || (others == 4'b0000));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick[2]) begin
          state_d = OWN;
          grant_d = 4'b0001 << pick[1:0];
          addr_d  = pick[1:0];
          hold_d  = 4'd1;
          last_d  = pick[1:0];
        end
      end
      OWN: begin
        if (keep) begin
          hold_d = (hold_q == MAX_Q) ? MAX_Q : hold_q + 4'd1;
        end else if (pick[2]) begin
          grant_d = 4'b0001 << pick[1:0];
          addr_d  = pick[1:0];
          hold_d  = 4'd1;
          last_d  = pick[1:0];
        end else begin
          state_d = IDLE;
          grant_d = 4'b0000;
          hold_d  = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        hold_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      addr_q  <= 2'b00;
      hold_q  <= 4'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // A case mux keeps X/Z on unselected inputs away from out.
  always_comb begin
    out_mux = '0;
    if (|grant_q) begin
      case (addr_q)
        2'd0:    out_mux = bus.in0;
        2'd1:    out_mux = bus.in1;
        2'd2:    out_mux = bus.in2;
        default: out_mux = bus.in3;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.address0 = addr_q[0];
  assign bus.address1 = addr_q[1];
  assign bus.valid    = |grant_q;
  assign bus.out      = out_mux;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with hand-computed grant and select sequences.
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.WIDTH(4)) bus ();

  rr_mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] a,
                         input logic v, input logic [3:0] o);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".addr"},  32'({bus.address1, bus.address0}), 32'(a));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".out"},   32'(bus.out), 32'(o));
  endtask

  initial begin
    int idx;
    reset_n = 1'b0;
    bus.req = 4'b0000;
    bus.in0 = 4'hx; bus.in1 = 4'hx; bus.in2 = 4'h1; bus.in3 = 4'hx;
    step(); step();
    chk_out("reset", 4'b0000, 2'b00, 1'b0, 4'h0);

    // Single request with X on the unselected inputs.
    reset_n = 1'b1;
    bus.req = 4'b0100;
    step();
    chk_out("single", 4'b0100, 2'b10, 1'b1, 4'h1);
    bus.in2 = 4'h0;
    #1;
    chk("single.follow", 32'(bus.out), 32'h0);
    bus.req = 4'b0000;
    step();
    chk_out("single.drop", 4'b0000, 2'b10, 1'b0, 4'h0);

    bus.in0 = 4'h1; bus.in1 = 4'h2; bus.in2 = 4'h4; bus.in3 = 4'h8;

    // last_owner=2 gives the order 3,0,1,2, so 0 wins first and 2 wins at the next release.
    bus.req = 4'b0101;
    step();
    chk_out("rot.first", 4'b0001, 2'b00, 1'b1, 4'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rot.hold", 32'(bus.grant), 32'h1);
    end
    step();
    chk_out("rot.second", 4'b0100, 2'b10, 1'b1, 4'h4);
    bus.req = 4'b0000;
    step();
    chk_out("rot.idle", 4'b0000, 2'b10, 1'b0, 4'h0);

    // Reset pulsed between edges, then all four request continuously.
    #2 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    bus.req = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      step();
      idx = ((k - 1) / 4) % 4;
      chk_out("all4", 4'(1 << idx), 2'(idx), 1'b1, 4'(1 << idx));
    end

    // Sole requester keeps the grant past MAX_HOLD.
    bus.req = 4'b0000;
    step();
    chk("sole.pre", 32'(bus.grant), 32'h0);
    bus.req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("sole.hold", 32'(bus.grant), 32'h2);
    end

    // Early drop by owner 0 hands off straight to 1, then idles with the address kept.
    bus.req = 4'b0000;
    step();
    bus.req = 4'b0011;
    step();
    chk_out("drop.own0", 4'b0001, 2'b00, 1'b1, 4'h1);
    bus.req = 4'b0010;
    step();
    chk_out("drop.handoff", 4'b0010, 2'b01, 1'b1, 4'h2);
    bus.req = 4'b0000;
    step();
    chk_out("drop.idle", 4'b0000, 2'b01, 1'b0, 4'h0);

    // Asynchronous reset while requester 3 owns the mux.
    bus.req = 4'b1000;
    step();
    chk_out("areset.pre", 4'b1000, 2'b11, 1'b1, 4'h8);
    #2 reset_n = 1'b0;
    #1;
    chk_out("areset.now", 4'b0000, 2'b00, 1'b0, 4'h0);
    reset_n = 1'b1;
    bus.req = 4'b1001;
    step();
    chk_out("areset.after", 4'b0001, 2'b00, 1'b1, 4'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
